// File: rtl/sequence_player_if.sv
// Player-facing bundle: pattern masks and transport controls in, trigger/step/status out.
// Master drives controls and masks; slave is the player.
interface sequence_player_if #(
    parameter int PERIOD_W = 8
);
    logic [1:0]          mode;
    logic                start_stop;
    logic                tempo_up;
    logic                tempo_down;
    logic [3:0]          seq_smpl_1;
    logic [3:0]          seq_smpl_2;
    logic [3:0]          seq_smpl_3;
    logic [3:0]          seq_smpl_4;
    logic [3:0]          seq_smpl_5;
    logic [3:0]          seq_smpl_6;
    logic [3:0]          seq_smpl_7;
    logic [3:0]          seq_smpl_8;
    logic [3:0]          smpl_trig;
    logic [2:0]          cur_step;
    logic                running;
    logic [PERIOD_W-1:0] step_period;

    modport master (
        output mode, start_stop, tempo_up, tempo_down,
        output seq_smpl_1, seq_smpl_2, seq_smpl_3, seq_smpl_4,
        output seq_smpl_5, seq_smpl_6, seq_smpl_7, seq_smpl_8,
        input  smpl_trig, cur_step, running, step_period
    );

    modport slave (
        input  mode, start_stop, tempo_up, tempo_down,
        input  seq_smpl_1, seq_smpl_2, seq_smpl_3, seq_smpl_4,
        input  seq_smpl_5, seq_smpl_6, seq_smpl_7, seq_smpl_8,
        output smpl_trig, cur_step, running, step_period
    );
endinterface

// File: rtl/sequence_player.sv
// Steps an 8-step x 4-sample pattern at a programmable tempo; SEQ_PLAYER_SWING_EN lengthens even / shortens odd steps.
// All outputs registered; trigger pulses on the step-entry edge; no backpressure (triggers are fire-and-forget).
module sequence_player #(
    parameter int PERIOD_W    = 8,
    parameter int PERIOD_INIT = 50,
    parameter int PERIOD_MIN  = 10,
    parameter int PERIOD_MAX  = 200,
    parameter int PERIOD_INC  = 5
) (
    input  logic             clk,
    input  logic             rst,
    sequence_player_if.slave sp
);
    localparam int PW1 = PERIOD_W + 1;
    localparam int CW  = PERIOD_W + 2;
`ifdef SEQ_PLAYER_SWING_EN
    localparam int CNT_W = PERIOD_W + 1;
`else
    localparam int CNT_W = PERIOD_W;
`endif

    localparam logic [PERIOD_W:0] P_MIN = PW1'(PERIOD_MIN);
    localparam logic [PERIOD_W:0] P_MAX = PW1'(PERIOD_MAX);
    localparam logic [PERIOD_W:0] P_INC = PW1'(PERIOD_INC);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_step;
    logic [3:0]          r_trig;
    logic                r_running;
    logic [PERIOD_W-1:0] r_period;

    logic                w_play;
    logic [PERIOD_W:0]   w_len;
    logic [CW-1:0]       w_cnt_inc;
    logic                w_boundary;
    logic [2:0]          w_step_nxt;
    logic [3:0]          w_mask_nxt;
    logic [PERIOD_W:0]   w_per_x;
    logic [PERIOD_W:0]   w_per_up;
    logic [PERIOD_W:0]   w_per_dn;
    logic [PERIOD_W:0]   w_per_nxt;

    assign w_play = (sp.mode == 2'd1);

`ifdef SEQ_PLAYER_SWING_EN
    logic [PERIOD_W:0] w_swing;
    assign w_swing = {3'b000, r_period[PERIOD_W-1:2]};
    // Even steps borrow a quarter period from the following odd step.
    assign w_len   = r_step[0] ? ({1'b0, r_period} - w_swing)
                               : ({1'b0, r_period} + w_swing);
`else
    assign w_len   = {1'b0, r_period};
`endif

    // >= rather than == so a tempo shrink below the running count advances next edge.
    assign w_cnt_inc  = CW'(r_cnt) + CW'(1);
    assign w_boundary = (w_cnt_inc >= CW'(w_len));
    assign w_step_nxt = r_step + 3'd1;

    always_comb begin
        w_mask_nxt = sp.seq_smpl_1;
        case (w_step_nxt)
            3'd1:    w_mask_nxt = sp.seq_smpl_2;
            3'd2:    w_mask_nxt = sp.seq_smpl_3;
            3'd3:    w_mask_nxt = sp.seq_smpl_4;
            3'd4:    w_mask_nxt = sp.seq_smpl_5;
            3'd5:    w_mask_nxt = sp.seq_smpl_6;
            3'd6:    w_mask_nxt = sp.seq_smpl_7;
            3'd7:    w_mask_nxt = sp.seq_smpl_8;
            default: w_mask_nxt = sp.seq_smpl_1;
        endcase
    end

    assign w_per_x  = {1'b0, r_period};
    assign w_per_up = (w_per_x < (P_MIN + P_INC)) ? P_MIN : (w_per_x - P_INC);
    assign w_per_dn = ((w_per_x + P_INC) > P_MAX) ? P_MAX : (w_per_x + P_INC);

    always_comb begin
        w_per_nxt = w_per_x;
        case ({sp.tempo_up, sp.tempo_down})
            2'b10:   w_per_nxt = w_per_up;
            2'b01:   w_per_nxt = w_per_dn;
            default: w_per_nxt = w_per_x;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_STOP;
            r_cnt     <= '0;
            r_step    <= '0;
            r_trig    <= '0;
            r_running <= 1'b0;
            r_period  <= PERIOD_W'(PERIOD_INIT);
        end else begin
            r_period <= w_per_nxt[PERIOD_W-1:0];
            r_trig   <= '0;
            case (r_state)
                ST_STOP: begin
                    r_cnt  <= '0;
                    r_step <= '0;
                    if (sp.start_stop && w_play) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                        r_trig    <= sp.seq_smpl_1;
                    end
                end
                ST_RUN, ST_PAUSE: begin
                    // Priority: stop, then pause, then step advance.
                    if (sp.start_stop) begin
                        r_state   <= ST_STOP;
                        r_running <= 1'b0;
                        r_cnt     <= '0;
                        r_step    <= '0;
                    end else if (!w_play) begin
                        r_state <= ST_PAUSE;
                    end else begin
                        r_state <= ST_RUN;
                        if (w_boundary) begin
                            r_cnt  <= '0;
                            r_step <= w_step_nxt;
                            r_trig <= w_mask_nxt;
                        end else begin
                            r_cnt <= w_cnt_inc[CNT_W-1:0];
                        end
                    end
                end
                default: begin
                    r_state   <= ST_STOP;
                    r_running <= 1'b0;
                    r_cnt     <= '0;
                    r_step    <= '0;
                end
            endcase
        end
    end

    assign sp.smpl_trig   = r_trig;
    assign sp.cur_step    = r_step;
    assign sp.running     = r_running;
    assign sp.step_period = r_period;
endmodule

// File: tb/tb_sequence_player.sv
// Bench for sequence_player: directed scenarios plus randomized traffic against a step-timing model.
`timescale 1ns/1ps
module tb_sequence_player;
    localparam int PW     = 8;
    localparam int P_INIT = 8;
    localparam int P_MIN  = 4;
    localparam int P_MAX  = 16;
    localparam int P_INC  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sequence_player_if #(.PERIOD_W(PW)) sp ();
    logic [3:0] masks [8];

    assign sp.seq_smpl_1 = masks[0];
    assign sp.seq_smpl_2 = masks[1];
    assign sp.seq_smpl_3 = masks[2];
    assign sp.seq_smpl_4 = masks[3];
    assign sp.seq_smpl_5 = masks[4];
    assign sp.seq_smpl_6 = masks[5];
    assign sp.seq_smpl_7 = masks[6];
    assign sp.seq_smpl_8 = masks[7];

    sequence_player #(
        .PERIOD_W   (PW),
        .PERIOD_INIT(P_INIT),
        .PERIOD_MIN (P_MIN),
        .PERIOD_MAX (P_MAX),
        .PERIOD_INC (P_INC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sp (sp.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: 0 = stopped, 1 = playing, 2 = paused; m_elapsed counts edges spent in the step.
    int         m_state;
    int         m_step;
    int         m_elapsed;
    int         m_period;
    logic [3:0] m_trig;

    function automatic int step_len(int s, int p);
        int q;
`ifdef SEQ_PLAYER_SWING_EN
        q = p / 4;
`else
        q = 0;
`endif
        return (s % 2 == 0) ? p + q : p - q;
    endfunction

    function automatic void m_reset();
        m_state   = 0;
        m_step    = 0;
        m_elapsed = 0;
        m_period  = P_INIT;
        m_trig    = 4'b0000;
    endfunction

    function automatic void m_edge(bit ss, logic [1:0] md, bit tu, bit td);
        int len;
        int np;
        len = step_len(m_step, m_period);
        np  = m_period;
        if (tu && !td) np = (m_period - P_INC < P_MIN) ? P_MIN : m_period - P_INC;
        if (td && !tu) np = (m_period + P_INC > P_MAX) ? P_MAX : m_period + P_INC;
        m_trig = 4'b0000;
        if (m_state == 0) begin
            if (ss && md == 2'd1) begin
                m_state   = 1;
                m_step    = 0;
                m_elapsed = 0;
                m_trig    = masks[0];
            end
        end else if (ss) begin
            m_state   = 0;
            m_step    = 0;
            m_elapsed = 0;
        end else if (md != 2'd1) begin
            m_state = 2;
        end else begin
            m_state   = 1;
            m_elapsed = m_elapsed + 1;
            if (m_elapsed >= len) begin
                m_elapsed = 0;
                m_step    = (m_step + 1) % 8;
                m_trig    = masks[m_step];
            end
        end
        m_period = np;
    endfunction

    task automatic tick();
        bit         ss;
        bit         tu;
        bit         td;
        logic [1:0] md;
        @(posedge clk);
        ss = sp.start_stop;
        tu = sp.tempo_up;
        td = sp.tempo_down;
        md = sp.mode;
        if (rst) m_reset();
        else     m_edge(ss, md, tu, td);
        #1;
        sp.start_stop = 1'b0;
        sp.tempo_up   = 1'b0;
        sp.tempo_down = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sp.mode = 2'd0; sp.start_stop = 1'b0; sp.tempo_up = 1'b0; sp.tempo_down = 1'b0;
        for (int i = 0; i < 8; i++) masks[i] = 4'($urandom_range(1, 15));
        m_reset();
        #2;
        n_checks++; if (sp.smpl_trig !== 4'b0000) $display("FAIL reset_trig: got %b want 0000", sp.smpl_trig); else n_pass++;
        n_checks++; if (sp.cur_step !== 3'd0) $display("FAIL reset_step: got %0d want 0", sp.cur_step); else n_pass++;
        n_checks++; if (sp.running !== 1'b0) $display("FAIL reset_running: got %b want 0", sp.running); else n_pass++;
        n_checks++; if (sp.step_period !== PW'(P_INIT)) $display("FAIL reset_period: got %0d want %0d", sp.step_period, P_INIT); else n_pass++;
        tick();
        rst = 1'b0;
        sp.start_stop = 1'b1;
        tick();
        n_checks++; if (sp.running !== 1'b0) $display("FAIL start_not_play_mode: got running=%b want 0", sp.running); else n_pass++;
        n_checks++; if (sp.smpl_trig !== 4'b0000) $display("FAIL start_not_play_trig: got %b want 0000", sp.smpl_trig); else n_pass++;
    endtask

    task automatic test_step_wrap();
        int next_bound;
        int s;
        logic [3:0] exp_trig;
        masks[0] = 4'b0001;
        masks[1] = 4'b0110;
        sp.mode = 2'd1;
        sp.start_stop = 1'b1;
        tick();
        n_checks++; if (sp.smpl_trig !== 4'b0001) $display("FAIL start_trig: got %b want 0001", sp.smpl_trig); else n_pass++;
        n_checks++; if (sp.running !== 1'b1) $display("FAIL start_running: got %b want 1", sp.running); else n_pass++;
        n_checks++; if (sp.cur_step !== 3'd0) $display("FAIL start_step: got %0d want 0", sp.cur_step); else n_pass++;
        s = 0;
        next_bound = step_len(0, P_INIT);
        for (int e = 1; e <= 64; e++) begin
            tick();
            exp_trig = 4'b0000;
            if (e == next_bound) begin
                s = (s + 1) % 8;
                exp_trig = masks[s];
                next_bound = next_bound + step_len(s, P_INIT);
            end
            n_checks++; if (sp.smpl_trig !== exp_trig) $display("FAIL step_trig e=%0d: got %b want %b", e, sp.smpl_trig, exp_trig); else n_pass++;
            n_checks++; if (sp.cur_step !== 3'(s)) $display("FAIL step_idx e=%0d: got %0d want %0d", e, sp.cur_step, s); else n_pass++;
        end
        n_checks++; if (sp.smpl_trig !== 4'b0001) $display("FAIL wrap_trig: got %b want 0001", sp.smpl_trig); else n_pass++;
        n_checks++; if (sp.cur_step !== 3'd0) $display("FAIL wrap_step: got %0d want 0", sp.cur_step); else n_pass++;
    endtask

    task automatic test_pause_resume();
        int k;
        for (int i = 0; i < 3; i++) tick();
        sp.mode = 2'd0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++; if (sp.smpl_trig !== 4'b0000) $display("FAIL pause_trig i=%0d: got %b want 0000", i, sp.smpl_trig); else n_pass++;
            n_checks++; if (sp.cur_step !== 3'd0) $display("FAIL pause_step i=%0d: got %0d want 0", i, sp.cur_step); else n_pass++;
            n_checks++; if (sp.running !== 1'b1) $display("FAIL pause_running i=%0d: got %b want 1", i, sp.running); else n_pass++;
        end
        sp.mode = 2'd1;
        k = 0;
        for (int i = 1; i <= 30 && k == 0; i++) begin
            tick();
            if (sp.smpl_trig !== 4'b0000) k = i;
        end
        n_checks++; if (k != step_len(0, P_INIT) - 3) $display("FAIL resume_edge: got %0d want %0d", k, step_len(0, P_INIT) - 3); else n_pass++;
        n_checks++; if (sp.smpl_trig !== masks[1]) $display("FAIL resume_trig: got %b want %b", sp.smpl_trig, masks[1]); else n_pass++;
        n_checks++; if (sp.cur_step !== 3'd1) $display("FAIL resume_step: got %0d want 1", sp.cur_step); else n_pass++;
    endtask

    task automatic test_tempo();
        int exp_p [9] = '{6, 4, 4, 6, 8, 10, 12, 14, 14};
        sp.start_stop = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) begin
            sp.tempo_up   = (i < 3 || i == 8);
            sp.tempo_down = (i >= 3);
            tick();
            n_checks++; if (sp.step_period !== PW'(exp_p[i])) $display("FAIL tempo i=%0d: got %0d want %0d", i, sp.step_period, exp_p[i]); else n_pass++;
        end
    endtask

    task automatic test_stop_priority();
        int guard;
        do_reset();
        sp.mode = 2'd1;
        sp.start_stop = 1'b1;
        tick();
        guard = 0;
        while (!(m_step == 5 && m_elapsed + 1 >= step_len(5, m_period)) && guard < 500) begin
            tick();
            guard++;
        end
        n_checks++; if (guard >= 500) $display("FAIL stop_reach_step5: got timeout want step 5 boundary"); else n_pass++;
        n_checks++; if (sp.cur_step !== 3'd5) $display("FAIL stop_pre_step: got %0d want 5", sp.cur_step); else n_pass++;
        sp.start_stop = 1'b1;
        tick();
        n_checks++; if (sp.smpl_trig !== 4'b0000) $display("FAIL stop_trig: got %b want 0000", sp.smpl_trig); else n_pass++;
        n_checks++; if (sp.cur_step !== 3'd0) $display("FAIL stop_step: got %0d want 0", sp.cur_step); else n_pass++;
        n_checks++; if (sp.running !== 1'b0) $display("FAIL stop_running: got %b want 0", sp.running); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++; if (sp.smpl_trig !== 4'b0000 || sp.running !== 1'b0) $display("FAIL stop_quiet i=%0d: got trig=%b run=%b want 0000/0", i, sp.smpl_trig, sp.running); else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        int guard;
        do_reset();
        sp.mode = 2'd1;
        sp.start_stop = 1'b1;
        sp.tempo_down = 1'b1;
        tick();
        guard = 0;
        while (m_step != 3 && guard < 500) begin
            tick();
            guard++;
        end
        tick();
        tick();
        n_checks++; if (sp.cur_step !== 3'd3 || sp.step_period !== PW'(P_INIT + P_INC)) $display("FAIL arst_pre: got step=%0d per=%0d want 3/%0d", sp.cur_step, sp.step_period, P_INIT + P_INC); else n_pass++;
        #3;
        rst = 1'b1;
        #1;
        n_checks++; if (sp.smpl_trig !== 4'b0000) $display("FAIL arst_trig: got %b want 0000", sp.smpl_trig); else n_pass++;
        n_checks++; if (sp.cur_step !== 3'd0) $display("FAIL arst_step: got %0d want 0", sp.cur_step); else n_pass++;
        n_checks++; if (sp.running !== 1'b0) $display("FAIL arst_running: got %b want 0", sp.running); else n_pass++;
        n_checks++; if (sp.step_period !== PW'(P_INIT)) $display("FAIL arst_period: got %0d want %0d", sp.step_period, P_INIT); else n_pass++;
        tick();
        rst = 1'b0;
        tick();
        n_checks++; if (sp.running !== 1'b0 || sp.smpl_trig !== 4'b0000) $display("FAIL arst_after: got run=%b trig=%b want 0/0000", sp.running, sp.smpl_trig); else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        sp.mode = 2'd1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0)
                sp.mode = (sp.mode == 2'd1) ? 2'($urandom_range(0, 3)) : 2'd1;
            sp.start_stop = ($urandom_range(0, 49) == 0);
            sp.tempo_up   = ($urandom_range(0, 14) == 0);
            sp.tempo_down = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 7) == 0) masks[$urandom_range(0, 7)] = 4'($urandom_range(0, 15));
            tick();
            n_checks++; if (sp.smpl_trig !== m_trig) $display("FAIL rnd_trig c=%0d: got %b want %b", c, sp.smpl_trig, m_trig); else n_pass++;
            n_checks++; if (sp.cur_step !== 3'(m_step)) $display("FAIL rnd_step c=%0d: got %0d want %0d", c, sp.cur_step, m_step); else n_pass++;
            n_checks++; if (sp.running !== (m_state != 0)) $display("FAIL rnd_running c=%0d: got %b want %b", c, sp.running, (m_state != 0)); else n_pass++;
            n_checks++; if (sp.step_period !== PW'(m_period)) $display("FAIL rnd_period c=%0d: got %0d want %0d", c, sp.step_period, m_period); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_step_wrap();
        test_pause_resume();
        test_tempo();
        test_stop_priority();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
